// File: rtl/pcpi_issuer.sv
// pcpi_issuer: initiator (CPU) side of the PCPI coprocessor interface.
// It accepts one host request and presents it on the PCPI bus. It then waits
// for a responder to finish or for the idle timeout to expire, and returns the
// outcome through a one-entry response buffer.
// Optional feature macro: PCPI_OPCODE_FILTER_EN. When it is defined, only
// M-extension encodings (opcode 0110011, funct7 0000001) are put on the bus.
// Every other accepted request completes at once as illegal.
module pcpi_issuer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        rsp_wr,
    output logic        rsp_illegal,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The count value at which one more idle cycle completes the timeout.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    // The saturation ceiling of the idle counter.
    localparam logic [CW-1:0] CNT_FULL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_idle_cnt;
    logic [31:0]   r_insn;
    logic [31:0]   r_rs1;
    logic [31:0]   r_rs2;
    logic [31:0]   r_rd;
    logic          r_wr;
    logic          r_illegal;

    logic          w_accept;
    logic          w_filter_pass;
    logic          w_idle_expire;

    assign w_accept = req_valid && req_ready;

`ifdef PCPI_OPCODE_FILTER_EN
    assign w_filter_pass = (req_insn[6:0] == 7'b0110011) && (req_insn[31:25] == 7'b0000001);
`else
    assign w_filter_pass = 1'b1;
`endif

    // A truly idle cycle (no ready, no wait) that brings the count up to TIMEOUT.
    // A ready pulse in that same cycle takes priority over the timeout.
    assign w_idle_expire = !pcpi_ready && !pcpi_wait && (r_idle_cnt >= CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_filter_pass ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                if (pcpi_ready || w_idle_expire) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM-decoded handshake outputs
    always_comb begin
        req_ready  = (r_state == S_IDLE) && !reset;
        pcpi_valid = (r_state == S_ISSUE);
        rsp_valid  = (r_state == S_RESP);
    end

    // Request capture, idle counting and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_insn     <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_wr       <= 1'b0;
            r_illegal  <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_insn     <= req_insn;
                        r_rs1      <= req_rs1;
                        r_rs2      <= req_rs2;
                        r_idle_cnt <= '0;
                        if (!w_filter_pass) begin
                            r_illegal <= 1'b1;
                            r_rd      <= '0;
                            r_wr      <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (pcpi_ready) begin
                        r_rd      <= pcpi_rd;
                        r_wr      <= pcpi_wr;
                        r_illegal <= 1'b0;
                    end else if (pcpi_wait) begin
                        r_idle_cnt <= '0;
                    end else begin
                        if (r_idle_cnt < CNT_FULL) begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                        if (w_idle_expire) begin
                            r_illegal <= 1'b1;
                            r_rd      <= '0;
                            r_wr      <= 1'b0;
                        end
                    end
                end
                default: begin
                    // RESP holds the buffered response untouched until consumed.
                end
            endcase
        end
    end

    assign pcpi_insn   = r_insn;
    assign pcpi_rs1    = r_rs1;
    assign pcpi_rs2    = r_rs2;
    assign rsp_rd      = r_rd;
    assign rsp_wr      = r_wr;
    assign rsp_illegal = r_illegal;

endmodule

// File: tb/tb_pcpi_issuer.sv
// Testbench for pcpi_issuer: directed scenarios with a transaction-level
// reference model, per-cycle output comparison and literal timing checks.
module tb_pcpi_issuer;

    localparam int TMO = 16;
    localparam logic [31:0] MUL_INSN = 32'h0200_0033;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_insn;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_wr;
    logic        rsp_illegal;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    pcpi_issuer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_illegal(rsp_illegal),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (one transaction in flight) ----------
    bit          m_init = 1'b0;
    bit          m_bus;       // instruction currently offered on the bus
    bit          m_rsp;       // response buffer full
    int          m_idle;      // length of the current run of idle bus cycles
    logic [31:0] m_insn, m_rs1, m_rs2, m_rd;
    logic        m_wr, m_ill;

    function automatic bit filtered_out(input logic [31:0] insn);
`ifdef PCPI_OPCODE_FILTER_EN
        return !((insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001));
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init <= 1'b1;
            m_bus  <= 1'b0;
            m_rsp  <= 1'b0;
            m_idle <= 0;
            m_insn <= '0; m_rs1 <= '0; m_rs2 <= '0;
            m_rd   <= '0; m_wr  <= 1'b0; m_ill <= 1'b0;
        end else if (m_rsp) begin
            if (rsp_ready) m_rsp <= 1'b0;
        end else if (m_bus) begin
            if (pcpi_ready) begin
                m_bus <= 1'b0; m_rsp <= 1'b1;
                m_rd <= pcpi_rd; m_wr <= pcpi_wr; m_ill <= 1'b0;
            end else if (pcpi_wait) begin
                m_idle <= 0;
            end else if (m_idle + 1 >= TMO) begin
                m_bus <= 1'b0; m_rsp <= 1'b1;
                m_rd <= '0; m_wr <= 1'b0; m_ill <= 1'b1;
            end else begin
                m_idle <= m_idle + 1;
            end
        end else if (req_valid) begin
            m_insn <= req_insn; m_rs1 <= req_rs1; m_rs2 <= req_rs2;
            m_idle <= 0;
            if (filtered_out(req_insn)) begin
                m_rsp <= 1'b1; m_rd <= '0; m_wr <= 1'b0; m_ill <= 1'b1;
            end else begin
                m_bus <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;
    int bus_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic compare_cycle();
        if (m_init) begin
            chk("pcpi_valid", pcpi_valid, m_bus);
            chk("rsp_valid", rsp_valid, m_rsp);
            chk("req_ready", req_ready, !reset && !m_bus && !m_rsp);
            if (m_bus) begin
                chk("pcpi_insn", pcpi_insn, m_insn);
                chk("pcpi_rs1", pcpi_rs1, m_rs1);
                chk("pcpi_rs2", pcpi_rs2, m_rs2);
            end
            if (m_rsp) begin
                chk("rsp_rd", rsp_rd, m_rd);
                chk("rsp_wr", rsp_wr, m_wr);
                chk("rsp_illegal", rsp_illegal, m_ill);
            end
        end
        if (pcpi_valid === 1'b1) bus_total++;
    endtask

    // One clock cycle: compare at the falling edge, then return 1 after the rising edge.
    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    int t_acc, bus_base, rsp_cyc;

    task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_insn = insn; req_rs1 = a; req_rs2 = b;
        t_acc = cyc;
        bus_base = bus_total;
        step();
        req_valid = 1'b0;
    endtask

    task automatic pulse_ready(input logic [31:0] rd, input logic wr);
        pcpi_ready = 1'b1; pcpi_rd = rd; pcpi_wr = wr;
        step();
        pcpi_ready = 1'b0; pcpi_rd = '0; pcpi_wr = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles);
        bit got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else step();
        end
        chk("rsp_arrived", got, 1'b1);
        rsp_cyc = cyc;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic report(input string name);
        $display("%s: accepted@%0d rsp@+%0d bus_cycles=%0d rd=%h wr=%0b illegal=%0b",
                 name, t_acc, rsp_cyc - t_acc, bus_total - bus_base, rsp_rd, rsp_wr, rsp_illegal);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] held_rd;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        rsp_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_pcpi_valid", pcpi_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rd", rsp_rd, 32'h0);
        chk("rst_rsp_wr", rsp_wr, 1'b0);
        chk("rst_rsp_illegal", rsp_illegal, 1'b0);
        chk("rst_pcpi_insn", pcpi_insn, 32'h0);
        chk("rst_pcpi_rs1", pcpi_rs1, 32'h0);
        chk("rst_pcpi_rs2", pcpi_rs2, 32'h0);
        reset = 1'b0;
        step();
        chk("idle_req_ready", req_ready, 1'b1);

        // 1: MUL 2*3 answered at T+3
        issue(MUL_INSN, 32'd2, 32'd3);
        step(); step();
        pulse_ready(32'h0000_0006, 1'b1);
        wait_rsp(10);
        chk("t1_latency", rsp_cyc - t_acc, 4);
        chk("t1_bus_cycles", bus_total - bus_base, 3);
        chk("t1_rd", rsp_rd, 32'h6);
        chk("t1_wr", rsp_wr, 1'b1);
        chk("t1_illegal", rsp_illegal, 1'b0);
        report("t1_mul");
        consume();

        // 2: silent responder -> timeout
        issue(MUL_INSN, 32'd5, 32'd9);
        wait_rsp(40);
        chk("t2_latency", rsp_cyc - t_acc, TMO + 1);
        chk("t2_bus_cycles", bus_total - bus_base, TMO);
        chk("t2_rd", rsp_rd, 32'h0);
        chk("t2_wr", rsp_wr, 1'b0);
        chk("t2_illegal", rsp_illegal, 1'b1);
        report("t2_timeout");
        consume();

        // 3: wait held for 40 cycles, then result
        issue(MUL_INSN, 32'h1111, 32'h2222);
        pcpi_wait = 1'b1;
        repeat (40) step();
        pcpi_wait = 1'b0;
        pulse_ready(32'hDEAD_BEEF, 1'b1);
        wait_rsp(10);
        chk("t3_latency", rsp_cyc - t_acc, 42);
        chk("t3_bus_cycles", bus_total - bus_base, 41);
        chk("t3_rd", rsp_rd, 32'hDEAD_BEEF);
        chk("t3_illegal", rsp_illegal, 1'b0);
        report("t3_wait");
        consume();

        // 5: ready coincides with the 16th idle cycle
        issue(MUL_INSN, 32'd7, 32'd1);
        repeat (TMO - 1) step();
        pulse_ready(32'h1234_5678, 1'b1);
        wait_rsp(10);
        chk("t5_latency", rsp_cyc - t_acc, TMO + 1);
        chk("t5_bus_cycles", bus_total - bus_base, TMO);
        chk("t5_rd", rsp_rd, 32'h1234_5678);
        chk("t5_illegal", rsp_illegal, 1'b0);
        report("t5_race");
        consume();

        // 4: response back-pressure, request waiting during the hold
        issue(MUL_INSN, 32'd7, 32'd8);
        pulse_ready(32'd56, 1'b1);
        wait_rsp(10);
        chk("t4_latency", rsp_cyc - t_acc, 2);
        held_rd = rsp_rd;
        req_valid = 1'b1; req_insn = MUL_INSN; req_rs1 = 32'hA; req_rs2 = 32'hB;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_req_ready", req_ready, 1'b0);
            chk("t4_hold_rsp_valid", rsp_valid, 1'b1);
            chk("t4_hold_rd", rsp_rd, 32'd56);
            step();
        end
        consume();
        chk("t4_ready_after", req_ready, 1'b1);
        t_acc = cyc;
        step();
        req_valid = 1'b0;
        chk("t4_new_issued", pcpi_valid, 1'b1);
        chk("t4_new_rs1", pcpi_rs1, 32'hA);
        pulse_ready(32'hB0, 1'b0);
        wait_rsp(10);
        chk("t4_new_rd", rsp_rd, 32'hB0);
        chk("t4_new_wr", rsp_wr, 1'b0);
        $display("t4_backpressure: held rd=%h, second request rd=%h", held_rd, rsp_rd);
        consume();

        // Stray pcpi_ready while idle is ignored
        pulse_ready(32'hFFFF_FFFF, 1'b1);
        step();
        chk("stray_rsp_valid", rsp_valid, 1'b0);
        chk("stray_pcpi_valid", pcpi_valid, 1'b0);
        $display("stray_ready: rsp_valid=%0b", rsp_valid);

        // 6: reset while in ISSUE
        issue(MUL_INSN, 32'd3, 32'd3);
        step(); step();
        chk("t6_in_issue", pcpi_valid, 1'b1);
        reset = 1'b1;
        step();
        chk("t6_pcpi_valid", pcpi_valid, 1'b0);
        chk("t6_rsp_valid", rsp_valid, 1'b0);
        chk("t6_req_ready_rst", req_ready, 1'b0);
        reset = 1'b0;
        step();
        chk("t6_req_ready", req_ready, 1'b1);
        $display("t6_reset: pcpi_valid=%0b rsp_valid=%0b", pcpi_valid, rsp_valid);

        // Non-M instruction (ADDI)
        issue(32'h0000_0013, 32'd1, 32'd2);
`ifdef PCPI_OPCODE_FILTER_EN
        chk("flt_rsp_now", rsp_valid, 1'b1);
        chk("flt_no_bus", pcpi_valid, 1'b0);
        wait_rsp(5);
        chk("flt_latency", rsp_cyc - t_acc, 1);
        chk("flt_bus_cycles", bus_total - bus_base, 0);
        chk("flt_illegal", rsp_illegal, 1'b1);
        chk("flt_rd", rsp_rd, 32'h0);
        report("t6_filter");
`else
        chk("nofilt_bus", pcpi_valid, 1'b1);
        pulse_ready(32'h55, 1'b0);
        wait_rsp(5);
        chk("nofilt_latency", rsp_cyc - t_acc, 2);
        chk("nofilt_illegal", rsp_illegal, 1'b0);
        chk("nofilt_rd", rsp_rd, 32'h55);
        report("t6_nofilter");
`endif
        consume();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
